// File: rtl/store_bus_writer_if.sv
// store_bus_writer_if: mnemonic type and data-bus write interface for store_bus_writer
//  master: bus_wr, bus_addr, bus_byteen, bus_wrdata out; bus_ack, bus_err in
//  slave : the reverse direction
package store_bus_writer_pkg;
  typedef enum logic [3:0] {
    MN_INVALID, LB, LH, LW, LBU, LHU, SB, SH, SW, ADDI
  } RV32I_INSTRUCTION_MNEMONIC_t;
endpackage

interface store_bus_writer_if;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wrdata;
  logic        bus_ack;
  logic        bus_err;
  modport master(output bus_wr, bus_addr, bus_byteen, bus_wrdata, input bus_ack, bus_err);
  modport slave(input bus_wr, bus_addr, bus_byteen, bus_wrdata, output bus_ack, bus_err);
endinterface

// File: rtl/store_bus_writer.sv
// store_bus_writer: turns an SB/SH/SW store into one byte-enabled write on the data bus
//  clk, rst (async, active-high); store_valid/mnemonic/store_addr/store_data from execute;
//  store_stall/store_done/store_fault to the core; bus (master modport) to the data bus.
//  Optional MISALIGN_TRAP_EN: misaligned SH/SW retire with a fault and never touch the bus.
module store_bus_writer
  import store_bus_writer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        store_valid,
  input  RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
  input  logic [31:0]                 store_addr,
  input  logic [31:0]                 store_data,
  output logic                        store_stall,
  output logic                        store_done,
  output logic                        store_fault,
  store_bus_writer_if.master          bus
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d, wrdata_q, wrdata_d;
  logic [3:0]       byteen_q, byteen_d;
  logic             fault_q, fault_d;
  logic [1:0]       a;
  logic [3:0]       lane_be;
  logic [31:0]      lane_data;
  logic             bad;

  assign a         = store_addr[1:0];
  assign lane_be   = mnemonic == SB ? 4'b0001 << a : mnemonic == SH ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign lane_data = mnemonic == SB ? {4{store_data[7:0]}} : mnemonic == SH ? {2{store_data[15:0]}} : store_data;
`ifdef MISALIGN_TRAP_EN
  assign bad = !(mnemonic inside {SB, SH, SW}) || (mnemonic == SH && a[0]) || (mnemonic == SW && a != 2'b00);
`else
  assign bad = !(mnemonic inside {SB, SH, SW});
`endif

  assign bus.bus_wr     = state_q == REQ;
  assign bus.bus_addr   = addr_q;
  assign bus.bus_byteen = byteen_q;
  assign bus.bus_wrdata = wrdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    byteen_d    = byteen_q;
    wrdata_d    = wrdata_q;
    fault_d     = fault_q;
    store_stall = 1'b0;
    store_done  = 1'b0;
    store_fault = 1'b0;
    case (state_q)
      IDLE: begin
        store_stall = store_valid;
        cnt_d       = '0;
        if (store_valid) begin
          addr_d   = {store_addr[31:2], 2'b00};
          byteen_d = lane_be;
          wrdata_d = lane_data;
          fault_d  = bad;
          state_d  = bad ? RESP : REQ;
        end
      end
      REQ: begin
        store_stall = 1'b1;
        cnt_d       = cnt_q + 1'b1;
        // an ack on the last allowed cycle still wins over the timeout
        if (bus.bus_ack) begin
          fault_d = bus.bus_err;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          fault_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        store_done  = 1'b1;
        store_fault = fault_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      byteen_q <= '0;
      wrdata_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      byteen_q <= byteen_d;
      wrdata_q <= wrdata_d;
      fault_q  <= fault_d;
    end
  end
endmodule

// File: tb/tb_store_bus_writer.sv
// tb_store_bus_writer: directed and randomized stores checked against a transaction-level model
module tb_store_bus_writer;
  import store_bus_writer_pkg::*;
  localparam int T = 16;
  typedef RV32I_INSTRUCTION_MNEMONIC_t mn_t;

  logic clk = 1'b0;
  logic rst, store_valid, store_stall, store_done, store_fault;
  mn_t mnemonic;
  logic [31:0] store_addr, store_data;
  store_bus_writer_if bif();

  store_bus_writer #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .store_valid(store_valid), .mnemonic(mnemonic),
    .store_addr(store_addr), .store_data(store_data), .store_stall(store_stall),
    .store_done(store_done), .store_fault(store_fault), .bus(bif)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: lanes by arithmetic, whether the store reaches the bus at all
  function automatic void model(input mn_t m, input logic [31:0] a, input logic [31:0] d,
                                output logic bad, output logic [3:0] be, output logic [31:0] wd);
    bad = !(m == SB || m == SH || m == SW);
`ifdef MISALIGN_TRAP_EN
    if ((m == SH && a[0]) || (m == SW && a[1:0] != 2'b00)) bad = 1'b1;
`endif
    be = m == SB ? 4'(1 << a[1:0]) : m == SH ? 4'(3 << (2 * a[1])) : 4'hF;
    wd = m == SB ? d[7:0] * 32'h01010101 : m == SH ? d[15:0] * 32'h00010001 : d;
  endfunction

  logic chk_en = 1'b0;
  logic e_stall = 1'b0, e_wr = 1'b0, e_done = 1'b0, e_fault = 1'b0;
  logic [31:0] e_addr = '0, e_wd = '0;
  logic [3:0] e_be = '0;
  int txn_id = 0;

  int seen_id = -1, wr_cyc = 0, stall_cyc = 0, done_cyc = 0;
  logic [31:0] cap_addr = '0, cap_wd = '0;
  logic [3:0] cap_be = '0;
  logic cap_fault = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (txn_id != seen_id) begin
        seen_id = txn_id; wr_cyc = 0; stall_cyc = 0; done_cyc = 0;
      end
      check("stall", 32'(store_stall), 32'(e_stall));
      check("bus_wr", 32'(bif.bus_wr), 32'(e_wr));
      check("done", 32'(store_done), 32'(e_done));
      check("fault", 32'(store_fault), 32'(e_fault));
      if (e_wr) begin
        check("bus_addr", bif.bus_addr, e_addr);
        check("bus_byteen", 32'(bif.bus_byteen), 32'(e_be));
        check("bus_wrdata", bif.bus_wrdata, e_wd);
      end
      if (bif.bus_wr) begin
        wr_cyc++; cap_addr = bif.bus_addr; cap_be = bif.bus_byteen; cap_wd = bif.bus_wrdata;
      end
      if (store_stall) stall_cyc++;
      if (store_done) begin done_cyc++; cap_fault = store_fault; end
    end
  end

  // dly = REQ cycle (1-based) on which the slave acks; beyond T means never
  task automatic run_store(input mn_t m, input logic [31:0] a, input logic [31:0] d,
                           input int dly, input logic err);
    logic bad, f;
    logic [3:0] be;
    logic [31:0] wd;
    int n;
    model(m, a, d, bad, be, wd);
    n = bad ? 0 : (dly <= T ? dly : T);
    f = bad ? 1'b1 : (dly <= T ? err : 1'b1);
    txn_id++;
    store_valid = 1'b1; mnemonic = m; store_addr = a; store_data = d;
    e_addr = {a[31:2], 2'b00}; e_be = be; e_wd = wd;
    for (int k = 0; k <= n + 1; k++) begin
      e_stall = k <= n;
      e_wr    = k >= 1 && k <= n;
      e_done  = k == n + 1;
      e_fault = k == n + 1 && f;
      bif.bus_ack = e_wr ? k == dly : 1'($urandom);
      bif.bus_err = (e_wr && k == dly) ? err : 1'($urandom);
      @(posedge clk); #1;
    end
    store_valid = 1'b0; bif.bus_ack = 1'b0; bif.bus_err = 1'b0;
    e_stall = 1'b0; e_wr = 1'b0; e_done = 1'b0; e_fault = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  mn_t pool [6] = '{SB, SH, SW, SW, LW, ADDI};

  initial begin
    rst = 1'b1; store_valid = 1'b0; mnemonic = SB; store_addr = '0; store_data = '0;
    bif.bus_ack = 1'b0; bif.bus_err = 1'b0;
    #1;
    check("rst bus_wr", 32'(bif.bus_wr), 0);
    check("rst bus_addr", bif.bus_addr, 0);
    check("rst bus_byteen", 32'(bif.bus_byteen), 0);
    check("rst bus_wrdata", bif.bus_wrdata, 0);
    check("rst done", 32'(store_done), 0);
    check("rst fault", 32'(store_fault), 0);
    check("rst stall idle", 32'(store_stall), 0);
    store_valid = 1'b1; #1;
    check("rst stall follows valid", 32'(store_stall), 1);
    store_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    chk_en = 1'b1;

    run_store(SB, 32'h1003, 32'hAABBCCDD, 1, 1'b0);
    check("sb addr", cap_addr, 32'h1000);
    check("sb byteen", 32'(cap_be), 32'b1000);
    check("sb wrdata", cap_wd, 32'hDDDDDDDD);
    check("sb wr cycles", wr_cyc, 1);
    check("sb stall cycles", stall_cyc, 2);
    check("sb done pulses", done_cyc, 1);
    check("sb fault", 32'(cap_fault), 0);

    run_store(SH, 32'h2002, 32'h00001234, 1, 1'b0);
    check("sh byteen", 32'(cap_be), 32'b1100);
    check("sh wrdata", cap_wd, 32'h12341234);
    check("sh fault", 32'(cap_fault), 0);

    run_store(SW, 32'h3000, 32'hCAFEF00D, 5, 1'b0);
    check("sw5 wr cycles", wr_cyc, 5);
    check("sw5 stall cycles", stall_cyc, 6);
    check("sw5 done pulses", done_cyc, 1);
    check("sw5 wrdata", cap_wd, 32'hCAFEF00D);

    run_store(SW, 32'h3000, 32'h12345678, 100, 1'b0);
    check("timeout wr cycles", wr_cyc, 16);
    check("timeout done pulses", done_cyc, 1);
    check("timeout fault", 32'(cap_fault), 1);

    run_store(SW, 32'h3000, 32'h0, 16, 1'b0);
    check("ack on last cycle wr cycles", wr_cyc, 16);
    check("ack on last cycle fault", 32'(cap_fault), 0);

    run_store(SW, 32'h3002, 32'h55AA55AA, 1, 1'b0);
`ifdef MISALIGN_TRAP_EN
    check("misalign wr cycles", wr_cyc, 0);
    check("misalign fault", 32'(cap_fault), 1);
`else
    check("misalign addr", cap_addr, 32'h3000);
    check("misalign byteen", 32'(cap_be), 32'hF);
    check("misalign fault", 32'(cap_fault), 0);
`endif
    check("misalign done pulses", done_cyc, 1);

    run_store(SW, 32'h3004, 32'h1, 2, 1'b1);
    check("bus err fault", 32'(cap_fault), 1);

    run_store(LW, 32'h3008, 32'h1, 1, 1'b0);
    check("invalid wr cycles", wr_cyc, 0);
    check("invalid fault", 32'(cap_fault), 1);

    chk_en = 1'b0;
    store_valid = 1'b1; mnemonic = SW; store_addr = 32'h4000; store_data = 32'h77;
    idle(2);
    check("pre-reset bus_wr", 32'(bif.bus_wr), 1);
    #1 rst = 1'b1;
    #1;
    check("async reset bus_wr", 32'(bif.bus_wr), 0);
    check("async reset done", 32'(store_done), 0);
    store_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("post-reset no done", 32'(store_done), 0);
      idle(1);
    end
    chk_en = 1'b1;
    run_store(SW, 32'h5000, 32'hFEEDBEEF, 2, 1'b0);
    check("post-reset done pulses", done_cyc, 1);
    check("post-reset fault", 32'(cap_fault), 0);
    check("post-reset wrdata", cap_wd, 32'hFEEDBEEF);

    for (int i = 0; i < 60; i++) begin
      run_store(pool[$urandom_range(0, 5)], $urandom, $urandom, $urandom_range(1, 20),
                $urandom_range(0, 3) == 0);
      check("rand done pulses", done_cyc, 1);
      idle($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
